gba_bk_ctrl: RTL and testbench

- Backup-save controller that sequences SD-card sector transfers between hps_io's sd_* interface and the backup save region in SDRAM (flash/EEPROM softmap area).
- Shares SDRAM channel 2 between the GBA core's bus_out port and its own copy engine.
- Holds a 512-byte sector buffer.
- Sits between gba_top, hps_io and the sdram ch2 ports in emu.

---
 rtl/gba_bk_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gba_bk_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_bk_ctrl.sv
// Backup-save controller: copies save sectors between the hps_io SD interface and the
// SDRAM save region through a 512-byte buffer, sharing SDRAM ch2 with the GBA bus.
module gba_bk_ctrl #(
  parameter logic [23:0] SAVE_BASE   = 24'h810000,
  parameter int unsigned SAVE_DWORDS = 34816
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic [8:0]  sector_count,
  output logic        busy,
  output logic        bk_loading,
  output logic        dirty,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  output logic [15:0] sd_buff_din,
  input  logic        sd_buff_wr,
  input  logic [23:0] gba_addr,
  input  logic [31:0] gba_wdata,
  output logic [31:0] gba_rdata,
  input  logic        gba_rnw,
  input  logic        gba_req,
  output logic        gba_ack,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        mem_rnw,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic [2:0]  dbg_state
);

  localparam int unsigned DW_PER_SECTOR = 128;
  localparam logic [23:0] SAVE_END      = SAVE_BASE + 24'(SAVE_DWORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_SD_REQ, S_SD_XFER, S_MEM_WR, S_NEXT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_load_d, r_save_d, r_ack_d;
  logic        r_mode_load;
  logic [8:0]  r_count, r_lba;
  logic [6:0]  r_cnt;
  logic        r_sd_rd, r_sd_wr;
  logic [15:0] r_sd_din;
  logic [15:0] r_buf [256];
  logic        r_out, r_own_gba, r_mem_req, r_mem_rnw;
  logic [23:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_gba_pend, r_gba_rnw, r_gba_ack;
  logic [23:0] r_gba_addr;
  logic [31:0] r_gba_wdata, r_gba_rdata;
  logic        r_dirty;

  logic        w_start_load, w_start_save, w_eng_phase;
  logic        w_issue_gba, w_issue_eng, w_eng_done, w_gba_done, w_last_dw, w_last_sector;
  logic [23:0] w_eng_addr;

  assign w_start_load  = (r_state == S_IDLE) & bk_load & ~r_load_d & (sector_count != 9'd0);
  assign w_start_save  = (r_state == S_IDLE) & bk_save & ~r_save_d & (sector_count != 9'd0)
                         & ~w_start_load;
  assign w_eng_phase   = (r_state == S_MEM_RD) | (r_state == S_MEM_WR);
  // mem_req is a one-cycle pulse; exactly one access stays outstanding (r_out) until the
  // one-cycle mem_ready. The pending GBA slot always beats the copy engine to a free channel.
  assign w_issue_gba   = ~r_out & r_gba_pend;
  assign w_issue_eng   = ~r_out & ~r_gba_pend & w_eng_phase;
  assign w_eng_done    = mem_ready & r_out & ~r_own_gba;
  assign w_gba_done    = mem_ready & r_out & r_own_gba;
  assign w_last_dw     = w_eng_done & (r_cnt == 7'(DW_PER_SECTOR - 1));
  assign w_last_sector = (r_lba == r_count - 9'd1);
  assign w_eng_addr    = SAVE_BASE + {8'd0, r_lba, 7'd0} + {17'd0, r_cnt};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_load) w_state_nxt = S_SD_REQ;
                 else if (w_start_save) w_state_nxt = S_MEM_RD;
      S_MEM_RD:  if (w_last_dw) w_state_nxt = S_SD_REQ;
      S_SD_REQ:  if (sd_ack) w_state_nxt = S_SD_XFER;
      S_SD_XFER: if (r_ack_d & ~sd_ack) w_state_nxt = r_mode_load ? S_MEM_WR : S_NEXT;
      S_MEM_WR:  if (w_last_dw) w_state_nxt = S_NEXT;
      S_NEXT:    if (w_last_sector) w_state_nxt = S_IDLE;
                 else w_state_nxt = r_mode_load ? S_SD_REQ : S_MEM_RD;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Sector buffer: SD side writes words, the engine fills a whole dword per read completion.
  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr) r_buf[sd_buff_addr] <= sd_buff_dout;
    if (w_eng_done && r_state == S_MEM_RD) begin
      r_buf[{r_cnt, 1'b0}] <= mem_dout[15:0];
      r_buf[{r_cnt, 1'b1}] <= mem_dout[31:16];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_load_d <= 1'b0; r_save_d <= 1'b0; r_ack_d <= 1'b0;
      r_mode_load <= 1'b0; r_count <= '0; r_lba <= '0; r_cnt <= '0;
      r_sd_rd <= 1'b0; r_sd_wr <= 1'b0; r_sd_din <= '0;
      r_out <= 1'b0; r_own_gba <= 1'b0; r_mem_req <= 1'b0; r_mem_rnw <= 1'b0;
      r_mem_addr <= '0; r_mem_din <= '0;
      r_gba_pend <= 1'b0; r_gba_rnw <= 1'b0; r_gba_addr <= '0; r_gba_wdata <= '0;
      r_gba_ack <= 1'b0; r_gba_rdata <= '0; r_dirty <= 1'b0;
    end else begin
      r_load_d <= bk_load;
      r_save_d <= bk_save;
      r_ack_d  <= sd_ack;
      r_sd_din <= r_buf[sd_buff_addr];

      if (w_start_load | w_start_save) begin
        r_mode_load <= w_start_load;
        r_count     <= sector_count;
        r_lba       <= '0;
        r_cnt       <= '0;
      end
      if (r_state == S_NEXT && !w_last_sector) r_lba <= r_lba + 9'd1;
      if (w_eng_done) r_cnt <= r_cnt + 7'd1;

      if (w_start_load || (r_state == S_NEXT && !w_last_sector && r_mode_load)) r_sd_rd <= 1'b1;
      if (r_state == S_MEM_RD && w_last_dw) r_sd_wr <= 1'b1;
      if (r_state == S_SD_REQ && sd_ack) begin
        r_sd_rd <= 1'b0;
        r_sd_wr <= 1'b0;
      end

      r_mem_req <= 1'b0;
      if (mem_ready && r_out) r_out <= 1'b0;
      if (w_issue_gba) begin
        r_mem_req  <= 1'b1; r_out <= 1'b1; r_own_gba <= 1'b1;
        r_mem_addr <= r_gba_addr; r_mem_din <= r_gba_wdata; r_mem_rnw <= r_gba_rnw;
        r_gba_pend <= 1'b0;
      end else if (w_issue_eng) begin
        r_mem_req  <= 1'b1; r_out <= 1'b1; r_own_gba <= 1'b0;
        r_mem_addr <= w_eng_addr;
        r_mem_din  <= {r_buf[{r_cnt, 1'b1}], r_buf[{r_cnt, 1'b0}]};
        r_mem_rnw  <= (r_state == S_MEM_RD);
      end
      if (gba_req) begin
        r_gba_pend  <= 1'b1;
        r_gba_addr  <= gba_addr;
        r_gba_wdata <= gba_wdata;
        r_gba_rnw   <= gba_rnw;
      end

      r_gba_ack <= w_gba_done;
      if (w_gba_done) r_gba_rdata <= mem_dout;

      // Clear at save start first so a same-cycle GBA write completion still marks dirty.
      if (w_start_save) r_dirty <= 1'b0;
      if (w_gba_done && !r_gba_rnw && r_gba_addr >= SAVE_BASE && r_gba_addr < SAVE_END)
        r_dirty <= 1'b1;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign bk_loading  = (r_state != S_IDLE) & r_mode_load;
  assign dirty       = r_dirty;
  assign sd_lba      = {23'd0, r_lba};
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign sd_buff_din = r_sd_din;
  assign gba_rdata   = r_gba_rdata;
  assign gba_ack     = r_gba_ack;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_rnw     = r_mem_rnw;
  assign mem_req     = r_mem_req;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_gba_bk_ctrl.sv
// Directed bench for gba_bk_ctrl with behavioural SD-card and SDRAM ch2 models.
module tb_gba_bk_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bk_load, bk_save;
  logic [8:0]  sector_count;
  logic        busy, bk_loading, dirty;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [23:0] gba_addr;
  logic [31:0] gba_wdata, gba_rdata;
  logic        gba_rnw, gba_req, gba_ack;
  logic [23:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_rnw, mem_req, mem_ready;
  logic [2:0]  dbg_state;

  always #5 clk_sys = ~clk_sys;

  gba_bk_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_load(bk_load), .bk_save(bk_save),
    .sector_count(sector_count), .busy(busy), .bk_loading(bk_loading), .dirty(dirty),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .gba_addr(gba_addr), .gba_wdata(gba_wdata),
    .gba_rdata(gba_rdata), .gba_rnw(gba_rnw), .gba_req(gba_req), .gba_ack(gba_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_rnw(mem_rnw),
    .mem_req(mem_req), .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_arr [logic [23:0]];
  logic [15:0] sd_got [256];
  logic [15:0] sd_xor;
  int          rd_cnt, wr_cnt;
  logic        sd_is_rd;
  logic [23:0] m_addr;
  logic [31:0] m_data;
  logic        m_rnw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SD card model: serves each sd_rd/sd_wr request with a 256-word transfer.
  initial begin
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !sd_ack) begin
        sd_is_rd = sd_rd;
        if (exp_q.size() > 0) check("sd_lba", sd_lba, exp_q.pop_front());
        else check("sd_req_unexpected", 32'd1, 32'd0);
        if (!sd_is_rd) check("reads_before_sd_wr", rd_cnt, 128);
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
          sd_buff_addr = 8'(i);
          if (sd_is_rd) begin
            sd_buff_dout = 16'(i) ^ sd_xor;
            sd_buff_wr   = 1'b1;
            @(negedge clk_sys);
          end else begin
            @(negedge clk_sys);
            sd_got[i] = sd_buff_din;
          end
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
      end
    end
  end

  // SDRAM ch2 model: one access at a time, 1..3 cycle latency.
  initial begin
    mem_ready = 1'b0; mem_dout = '0;
    forever begin
      @(negedge clk_sys);
      if (mem_req) begin
        m_addr = mem_addr; m_data = mem_din; m_rnw = mem_rnw;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        if (m_rnw) begin
          mem_dout = mem_arr.exists(m_addr) ? mem_arr[m_addr] : 32'd0;
          rd_cnt++;
        end else begin
          mem_arr[m_addr] = m_data;
          wr_cnt++;
        end
        mem_ready = 1'b1;
        @(negedge clk_sys);
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_req(input logic l, input logic s, input logic [8:0] cnt);
    @(negedge clk_sys);
    sector_count = cnt; bk_load = l; bk_save = s;
    @(negedge clk_sys);
    bk_load = 1'b0; bk_save = 1'b0;
  endtask

  task automatic gba_op(input logic rnw, input logic [23:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic seen;
    seen = 1'b0; rd = '0;
    @(negedge clk_sys);
    gba_req = 1'b1; gba_rnw = rnw; gba_addr = a; gba_wdata = wd;
    @(negedge clk_sys);
    gba_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (gba_ack) begin
        seen = 1'b1; rd = gba_rdata;
        break;
      end
      @(negedge clk_sys);
    end
    check("gba_ack_seen", seen, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 6000 && busy; i++) @(negedge clk_sys);
    check(tag, busy, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        hit;
    int          errs;
    reset_n = 1'b0; bk_load = 1'b0; bk_save = 1'b0; sector_count = '0;
    gba_addr = '0; gba_wdata = '0; gba_rnw = 1'b1; gba_req = 1'b0;
    sd_xor = '0; rd_cnt = 0; wr_cnt = 0;
    repeat (3) @(negedge clk_sys);
    check("rst_busy", busy, 0);
    check("rst_loading", bk_loading, 0);
    check("rst_dirty", dirty, 0);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_gba_ack", gba_ack, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;

    // Load two sectors, SD supplies words 0x0000..0x00FF each.
    exp_q = '{32'd0, 32'd1}; wr_cnt = 0;
    start_req(1'b1, 1'b0, 9'd2);
    check("load_busy", busy, 1);
    check("load_loading", bk_loading, 1);
    check("load_sd_rd", sd_rd, 1);
    wait_idle("load_done");
    check("load_writes", wr_cnt, 256);
    check("load_loading_off", bk_loading, 0);
    check("load_w810000", mem_arr[24'h810000], 32'h0001_0000);
    check("load_w81007f", mem_arr[24'h81007F], 32'h00FF_00FE);
    check("load_w810080", mem_arr[24'h810080], 32'h0001_0000);
    check("load_w8100ff", mem_arr[24'h8100FF], 32'h00FF_00FE);
    check("load_q_empty", exp_q.size(), 0);

    // Dirty tracking window boundaries.
    gba_op(1'b0, 24'h800000, 32'h1111_1111, rd);
    check("dirty_below", dirty, 0);
    gba_op(1'b0, 24'h818800, 32'h2222_2222, rd);
    check("dirty_above", dirty, 0);
    gba_op(1'b0, 24'h810010, 32'h3333_3333, rd);
    check("dirty_inside", dirty, 1);

    // Save one sector from a known SDRAM pattern.
    for (int k = 0; k < 128; k++) mem_arr[24'h810000 + 24'(k)] = 32'hA500_0000 + 32'(k);
    exp_q = '{32'd0}; rd_cnt = 0;
    start_req(1'b0, 1'b1, 9'd1);
    check("save_busy", busy, 1);
    check("save_loading", bk_loading, 0);
    check("save_dirty_clr", dirty, 0);
    for (int i = 0; i < 2000 && rd_cnt < 20; i++) @(negedge clk_sys);
    check("save_mid_state", dbg_state, 3'd1);
    gba_op(1'b0, 24'h818000, 32'h4444_4444, rd);
    check("save_dirty_mid", dirty, 1);
    wait_idle("save_done");
    check("save_w0", sd_got[0], 16'h0000);
    check("save_w1", sd_got[1], 16'hA500);
    check("save_w2", sd_got[2], 16'h0001);
    check("save_w254", sd_got[254], 16'h007F);
    check("save_w255", sd_got[255], 16'hA500);
    check("save_dirty_end", dirty, 1);

    // GBA read interleaved with engine writes.
    mem_arr[24'h000100] = 32'hDEAD_BEEF;
    sd_xor = 16'h5A00; exp_q = '{32'd0}; wr_cnt = 0;
    start_req(1'b1, 1'b0, 9'd1);
    for (int i = 0; i < 3000 && !(dbg_state == 3'd4 && wr_cnt >= 10); i++) @(negedge clk_sys);
    check("mix_in_mem_wr", dbg_state, 3'd4);
    gba_op(1'b1, 24'h000100, 32'd0, rd);
    check("mix_gba_rdata", rd, 32'hDEAD_BEEF);
    wait_idle("mix_done");
    check("mix_writes", wr_cnt, 128);
    errs = 0;
    for (int k = 0; k < 128; k++)
      if (mem_arr[24'h810000 + 24'(k)] !== {16'(2*k+1) ^ 16'h5A00, 16'(2*k) ^ 16'h5A00}) errs++;
    check("mix_wr_data_errs", errs, 0);

    // Simultaneous edges and zero-count requests.
    sd_xor = '0; exp_q = '{32'd0};
    start_req(1'b1, 1'b1, 9'd1);
    check("both_sd_rd", sd_rd, 1);
    check("both_loading", bk_loading, 1);
    wait_idle("both_done");
    start_req(1'b1, 1'b0, 9'd0);
    repeat (2) @(negedge clk_sys);
    check("zero_load_busy", busy, 0);
    start_req(1'b0, 1'b1, 9'd0);
    repeat (2) @(negedge clk_sys);
    check("zero_save_busy", busy, 0);

    // Reset during the data phase of sector 1.
    exp_q = '{32'd0, 32'd1};
    start_req(1'b1, 1'b0, 9'd2);
    hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (dbg_state == 3'd3 && sd_lba == 32'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("rst2_reached_xfer1", hit, 1);
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("rst2_busy", busy, 0);
    check("rst2_loading", bk_loading, 0);
    check("rst2_dirty", dirty, 0);
    check("rst2_sd_rd", sd_rd, 0);
    check("rst2_sd_lba", sd_lba, 0);
    check("rst2_state", dbg_state, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_gba_rdata", gba_rdata, 0);
    check("rst2_sd_din", sd_buff_din, 0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 1000 && sd_ack; i++) @(negedge clk_sys);
    check("rst2_ack_low", sd_ack, 0);
    exp_q = '{32'd0};
    start_req(1'b1, 1'b0, 9'd1);
    check("restart_lba", sd_lba, 0);
    check("restart_sd_rd", sd_rd, 1);
    wait_idle("restart_done");
    check("restart_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
